// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_pkg
//   Shared types and constants for the fetch-stage next-PC generator.
//   - fetch_state_e : fetch FSM states (BOOT, FETCH, REDIR)
//   - DEFAULT_RESET_PC : default first fetch address after reset
//   - pc_inc() : sequential next-PC, 32-bit wrap
// -----------------------------------------------------------------------------
package fetch_pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,   // one idle cycle after reset so imem can settle
      ST_FETCH = 2'd1,   // request valid, advancing on ready
      ST_REDIR = 2'd2    // one-cycle bubble after a mispredict flush
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequential fall-through address; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
//   Instruction-memory request channel of the fetch stage.
//   inst_req_valid : fetch request valid            (master -> slave)
//   inst_req_ready : imem accepts request this cycle (slave -> master)
//   inst_pc        : fetch address                   (master -> slave)
//   pred_taken     : prediction attached to inst_pc  (master -> slave)
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if;

   logic        inst_req_valid;
   logic        inst_req_ready;
   logic [31:0] inst_pc;
   logic        pred_taken;

   modport master (
      output inst_req_valid,
      output inst_pc,
      output pred_taken,
      input  inst_req_ready
   );

   modport slave (
      input  inst_req_valid,
      input  inst_pc,
      input  pred_taken,
      output inst_req_ready
   );

endinterface

// File: rtl/fetch_pc_gen_btb.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_btb
//   Direct-mapped branch target buffer. Combinational lookup, single write port.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits)
//   lookup_pc     : address to look up
//   hit, target   : lookup result (valid && tag match), stored target
//   upd_valid     : write enable; entry overwritten, no replacement policy
//   upd_pc        : address of the resolved branch (selects index and tag)
//   upd_target    : resolved target stored in the entry
// -----------------------------------------------------------------------------
module fetch_pc_gen_btb #(
   parameter int BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX - 2;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [31:0]            target_q [BTB_ENTRIES];

   logic [IDX-1:0]   lookup_idx;
   logic [TAG_W-1:0] lookup_tag;
   logic [IDX-1:0]   upd_idx;
   logic [TAG_W-1:0] upd_tag;

   assign lookup_idx = lookup_pc[IDX+1:2];
   assign lookup_tag = lookup_pc[31:IDX+2];
   assign upd_idx    = upd_pc[IDX+1:2];
   assign upd_tag    = upd_pc[31:IDX+2];

   // Reads see the registered arrays only, so a same-cycle write to the looked-up
   // index returns the old contents.
   assign hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
   assign target = target_q[lookup_idx];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (upd_valid) begin
         valid_q[upd_idx] <= 1'b1;
      end
   end

   // NOTE: only the valid bits are reset; tag/target contents are don't-care
   // while invalid, so leaving them unreset keeps them plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && upd_valid) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Fetch-stage next-PC generator. Holds the fetch PC, issues valid/ready
//   requests to instruction memory and chooses the next PC from a BTB combined
//   with the global predictor direction.
//   clk, rst     : clock, synchronous active-high reset
//   prdct_br_go  : predictor direction, 1 = taken
//   cancle       : EX mispredict/flush pulse; redirect_pc sampled with it
//   redirect_pc  : correct PC from EX
//   upd_valid    : BTB write enable; upd_pc / upd_target give entry contents
//   imem         : request channel (inst_req_valid/ready, inst_pc, pred_taken)
// -----------------------------------------------------------------------------
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prdct_br_go,
   input  logic             cancle,
   input  logic [31:0]      redirect_pc,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_target,
   fetch_pc_gen_if.master   imem
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         btb_hit;
   logic [31:0]  btb_target;
   logic         predict;
   logic [31:0]  next_pc;
   logic         req_valid;

   fetch_pc_gen_btb #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .lookup_pc  (pc_q),
      .hit        (btb_hit),
      .target     (btb_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target)
   );

   // A BTB miss forces not-taken: without a target the direction is useless.
   assign predict = btb_hit && prdct_br_go;
   assign next_pc = predict ? btb_target : pc_inc(pc_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_valid = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            req_valid = 1'b1;
            // Flush outranks a handshake: the request in flight is killed.
            if (cancle) begin
               pc_d    = redirect_pc;
               state_d = ST_REDIR;
            end else if (imem.inst_req_ready) begin
               pc_d = next_pc;
            end
         end
         ST_REDIR: begin
            if (cancle) begin
               pc_d = redirect_pc;
            end else begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign imem.inst_req_valid = req_valid;
   assign imem.inst_pc        = pc_q;
   assign imem.pred_taken     = predict;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed bench for fetch_pc_gen: sequential fetch, stalls, BTB hit/miss,
//   flush priority, BTB aliasing, same-cycle write/lookup and reset recovery.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        prdct_br_go;
   logic        cancle;
   logic [31:0] redirect_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;

   int checks = 0;
   int errors = 0;

   fetch_pc_gen_if imem ();

   fetch_pc_gen #(
      .BTB_ENTRIES (16),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .prdct_br_go (prdct_br_go),
      .cancle      (cancle),
      .redirect_pc (redirect_pc),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .imem        (imem.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input string tag, input logic valid, input logic [31:0] pc);
      #1;
      check({tag, ".valid"}, {31'd0, imem.inst_req_valid}, {31'd0, valid});
      if (valid) check({tag, ".pc"}, imem.inst_pc, pc);
   endtask

   task automatic expect_pred(input string tag, input logic exp);
      #1;
      check({tag, ".pred"}, {31'd0, imem.pred_taken}, {31'd0, exp});
   endtask

   // Flush to pc: one REDIR bubble, then FETCH at pc.
   task automatic redirect_to(input logic [31:0] pc);
      cancle      = 1'b1;
      redirect_pc = pc;
      tick();
      cancle      = 1'b0;
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      prdct_br_go = 1'b0;
      cancle      = 1'b0;
      redirect_pc = '0;
      upd_valid   = 1'b0;
      upd_pc      = '0;
      upd_target  = '0;
      imem.inst_req_ready = 1'b1;

      // 1: reset state, one bubble, then sequential fetch
      tick();
      tick();
      expect_req("rst_valid", 1'b0, 32'h0);
      check("rst_pc", imem.inst_pc, 32'h0);
      expect_pred("rst", 1'b0);
      rst = 1'b0;
      expect_req("boot", 1'b0, 32'h0);
      tick();
      expect_req("seq0", 1'b1, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         expect_req($sformatf("seq%0d", i), 1'b1, 32'(i * 4));
      end

      // 2: stall three cycles at 0x10
      imem.inst_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_req($sformatf("stall%0d", i), 1'b1, 32'h10);
      end
      imem.inst_req_ready = 1'b1;
      tick();
      expect_req("unstall", 1'b1, 32'h14);

      // 3: BTB install 0x20->0x80, taken and not-taken fetches
      upd_valid  = 1'b1;
      upd_pc     = 32'h20;
      upd_target = 32'h80;
      tick();
      upd_valid = 1'b0;
      expect_req("upd_seq", 1'b1, 32'h18);
      tick();
      tick();
      expect_req("at20", 1'b1, 32'h20);
      prdct_br_go = 1'b1;
      expect_pred("hit_taken", 1'b1);
      tick();
      expect_req("taken_tgt", 1'b1, 32'h80);
      prdct_br_go = 1'b0;
      redirect_to(32'h20);
      expect_req("back20", 1'b1, 32'h20);
      expect_pred("hit_nt", 1'b0);
      tick();
      expect_req("nt_seq", 1'b1, 32'h24);
      prdct_br_go = 1'b1;
      expect_pred("miss_go", 1'b0);
      prdct_br_go = 1'b0;

      // 4: flush while stalled, then flush coinciding with ready
      redirect_to(32'h40);
      imem.inst_req_ready = 1'b0;
      expect_req("at40", 1'b1, 32'h40);
      cancle      = 1'b1;
      redirect_pc = 32'h100;
      tick();
      cancle = 1'b0;
      imem.inst_req_ready = 1'b1;
      expect_req("bubble", 1'b0, 32'h0);
      tick();
      expect_req("redir100", 1'b1, 32'h100);
      redirect_to(32'h40);
      cancle      = 1'b1;
      redirect_pc = 32'h100;
      tick();
      cancle = 1'b0;
      expect_req("cr_bubble", 1'b0, 32'h0);
      check("cr_pc", imem.inst_pc, 32'h100);
      tick();
      expect_req("cr_win", 1'b1, 32'h100);
      tick();
      expect_req("cr_seq", 1'b1, 32'h104);
      // back-to-back flush while in the bubble: the later one wins
      cancle      = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_pc = 32'h300;
      tick();
      cancle = 1'b0;
      expect_req("redir2_bub", 1'b0, 32'h0);
      tick();
      expect_req("redir2", 1'b1, 32'h300);

      // 5: alias 0x60 evicts 0x20, then same-cycle write and lookup
      upd_valid  = 1'b1;
      upd_pc     = 32'h60;
      upd_target = 32'hC0;
      tick();
      upd_valid = 1'b0;
      redirect_to(32'h20);
      prdct_br_go = 1'b1;
      expect_pred("alias_miss", 1'b0);
      tick();
      expect_req("alias_seq", 1'b1, 32'h24);
      redirect_to(32'h60);
      expect_pred("alias_hit", 1'b1);
      upd_valid  = 1'b1;
      upd_pc     = 32'h60;
      upd_target = 32'h200;
      tick();
      upd_valid = 1'b0;
      expect_req("old_tgt", 1'b1, 32'hC0);
      redirect_to(32'h60);
      tick();
      expect_req("new_tgt", 1'b1, 32'h200);

      // 6: reset from REDIR, then from a stalled FETCH with a BTB write pending
      cancle      = 1'b1;
      redirect_pc = 32'h400;
      tick();
      cancle = 1'b0;
      rst    = 1'b1;
      tick();
      rst = 1'b0;
      expect_req("rst_redir", 1'b0, 32'h0);
      check("rst_redir_pc", imem.inst_pc, 32'h0);
      tick();
      expect_req("rst_redir_f", 1'b1, 32'h0);
      redirect_to(32'h60);
      expect_pred("btb_clr", 1'b0);
      imem.inst_req_ready = 1'b0;
      rst        = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h60;
      upd_target = 32'h500;
      tick();
      rst       = 1'b0;
      upd_valid = 1'b0;
      expect_req("rst_fetch", 1'b0, 32'h0);
      check("rst_fetch_pc", imem.inst_pc, 32'h0);
      tick();
      expect_req("rst_fetch_f", 1'b1, 32'h0);
      redirect_to(32'h60);
      expect_pred("upd_in_rst", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
